// File: rtl/seg_scan_hex.sv
// =============================================================================
// Module   : seg_scan_hex
// Brief    : 8-digit multiplexed hex display scanner, anti-ghost, zero blanking
// Revision : 1.0
// =============================================================================
`default_nettype none

module seg_scan_hex #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_locked,
    input  logic        i_load,
    input  logic [31:0] i_value,
    input  logic        i_blank_zero,
    output logic [7:0]  o_an,
    output logic [7:0]  o_seg
);

    localparam int                 c_CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

    logic [31:0]        r_shown;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_an;
    logic [7:0]         r_seg;

    logic [3:0]         w_nibble;
    logic [6:0]         w_font;
    logic               w_upper_zero;
    logic               w_blank;

    assign w_nibble     = r_shown[{r_idx, 2'b00} +: 4];
    // Leading zero: this nibble and every more-significant one are zero.
    assign w_upper_zero = (r_shown >> {r_idx, 2'b00}) == 32'd0;
    assign w_blank      = i_blank_zero && (r_idx != 3'd0) && w_upper_zero;

    always_comb begin
        w_font = 7'h7F;
        case (w_nibble)
            4'h0: w_font = 7'h40;
            4'h1: w_font = 7'h79;
            4'h2: w_font = 7'h24;
            4'h3: w_font = 7'h30;
            4'h4: w_font = 7'h19;
            4'h5: w_font = 7'h12;
            4'h6: w_font = 7'h02;
            4'h7: w_font = 7'h78;
            4'h8: w_font = 7'h00;
            4'h9: w_font = 7'h10;
            4'hA: w_font = 7'h08;
            4'hB: w_font = 7'h03;
            4'hC: w_font = 7'h46;
            4'hD: w_font = 7'h21;
            4'hE: w_font = 7'h06;
            4'hF: w_font = 7'h0E;
            default: w_font = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shown <= 32'd0;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_an    <= 8'hFF;
            r_seg   <= 8'hFF;
        end else if (!i_locked) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_an    <= 8'hFF;
            r_seg   <= 8'hFF;
        end else begin
            if (i_load) begin
                r_shown <= i_value;
            end
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // First cycle of each slot is dark so the previous digit cannot ghost.
            if (r_cnt == '0) begin
                r_an  <= 8'hFF;
                r_seg <= 8'hFF;
            end else begin
                r_an  <= ~(8'b1 << r_idx);
                r_seg <= w_blank ? 8'hFF : {1'b1, w_font};
            end
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

`default_nettype wire

// File: doc/seg_scan_hex.md
SEG_SCAN_HEX -- requirements
Module: seg_scan_hex

Interface
REQ-001 SCAN_DIV, 100000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 clk  in  1  system clock; all state on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 locked  in  1  clock-good qualifier; scanning and loads occur only while 1.
REQ-005 load  in  1  single-cycle strobe; captures value.
REQ-006 value  in  32  calculator result to display, 8 hex nibbles, nibble 0 = bits [3:0].
REQ-007 blank_zero  in  1  leading-zero suppression enable.
REQ-008 an  out  8  digit enables, active-low, an[i] drives digit i (0 = rightmost).
REQ-009 seg  out  8  segments, active-low, seg[0]=a .. seg[6]=g, seg[7]=dp.

Function
REQ-010 Internal state SHALL be: shown (32b display latch), cnt (slot counter 0..SCAN_DIV-1), idx (3b digit index).
REQ-011 With locked=1 and load=1, shown SHALL take value at that edge; with locked=0, load SHALL be ignored.
REQ-012 With locked=1, cnt SHALL increment each cycle; at cnt=SCAN_DIV-1 it SHALL wrap to 0 and idx SHALL increment, 7 wrapping to 0.
REQ-013 With locked=0, cnt and idx SHALL be forced to 0 synchronously, shown SHALL hold, an and seg SHALL be registered to 8'hFF.
REQ-014 an and seg SHALL be registered; each edge with locked=1 SHALL compute them from the pre-edge cnt, idx, shown, blank_zero (one-cycle output latency).
REQ-015 Anti-ghost: when pre-edge cnt=0, an SHALL be 8'hFF and seg 8'hFF; otherwise an SHALL be ~(8'b1 << idx).
REQ-016 seg[6:0] SHALL be the standard hex font of nibble idx of shown; seg[7] (dp) SHALL always be 1 (off).
REQ-017 Font check values: 0 -> 8'hC0, 8 -> 8'h80, A -> 8'h88, b -> 8'h83, F -> 8'h8E.
REQ-018 Blanking: when blank_zero=1 and idx>0 and nibbles idx..7 of shown are all zero, seg SHALL be 8'hFF while an still selects the digit.
REQ-019 Digit 0 SHALL never be blanked; value 0 with blank_zero=1 SHALL display a single "0".
REQ-020 load coincident with a slot wrap: idx SHALL advance and shown SHALL update at the same edge; the new digit SHALL use the new shown.
REQ-021 blank_zero changes SHALL take effect on the next output register update, with no state of their own.
REQ-022 locked deasserting mid-slot SHALL abandon the slot; on reassert scanning SHALL restart at idx=0, cnt=0.

Reset
REQ-023 rst=1 SHALL asynchronously set shown=0, cnt=0, idx=0, an=8'hFF, seg=8'hFF.
REQ-024 rst asserted mid-scan or coincident with load SHALL win; the load SHALL be lost.
REQ-025 After rst deasserts with locked=1, the first non-blank output SHALL appear on the edge following cnt=1 of digit 0.

Verification (SCAN_DIV=4 unless noted)
REQ-026 rst pulse, locked=1, load value=32'h1234ABCF, blank_zero=0 -> over 8 slots an walks FE,FD,..,7F, seg F:8E, C:C6, B:83, A:88, 4:99, 3:B0, 2:A4, 1:F9; an=FF on each slot's first output cycle.
REQ-027 value=32'h0000_00A0, blank_zero=1 -> digits 0,1 show C0, 88; digits 2..7 an active, seg=FF; with blank_zero=0 digits 2..7 show C0.
REQ-028 value=0, blank_zero=1 -> digit 0 shows C0, all other slots seg=FF.
REQ-029 locked dropped during slot idx=5 -> next edge an=FF, seg=FF, load ignored; on reassert scan restarts at digit 0 with shown unchanged.
REQ-030 rst asserted asynchronously mid-slot with load=1 -> an=FF, seg=FF immediately, shown=0 after release; SCAN_DIV=2 repeat of REQ-026 passes.
